// File: rtl/fifo_pkg.sv
// Shared width helpers for the synchronous FIFO: address, pointer (address + wrap bit)
// and occupancy counter widths, all derived from the memory depth.
package fifo_pkg;

  localparam int DEF_DEPTH = 1024;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  // Count also covers the two output-stage words, so it needs one bit beyond the pointer.
  function automatic int cnt_w(input int depth);
    return addr_w(depth) + 2;
  endfunction

endpackage

// File: rtl/fifo_bram.sv
// Simple dual-port memory, one write port and one registered read port (1-cycle latency).
// No flow control of its own; the controller decides when to write and read.
module fifo_bram
  import fifo_pkg::*;
#(
  parameter int P_DEPTH = 1024,
  parameter int P_WIDTH = 8,
  localparam int AW = addr_w(P_DEPTH)
) (
  input  logic               wr_clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [P_WIDTH-1:0] wr_data,
  input  logic               rd_clk,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [P_WIDTH-1:0] rd_data
);

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// First-word-fall-through FIFO around fifo_bram: first word visible 2 cycles after push,
// 1 word/cycle streaming; s_ready drops when the memory is full, m_data holds while stalled.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int P_DEPTH  = 1024,
  parameter int P_WIDTH  = 8,
  parameter int P_AFULL  = P_DEPTH - 16,
  parameter int P_AEMPTY = 16,
  localparam int CW = cnt_w(P_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [P_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam int AW = addr_w(P_DEPTH);
  localparam int PW = ptr_w(P_DEPTH);

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               mem_empty;
  logic               push;
  logic               pop;
  logic               issue;
  logic               land;
  logic [1:0]         out_cnt;
  logic [1:0]         out_cnt_nxt;
  logic [P_WIDTH-1:0] out0;
  logic [P_WIDTH-1:0] out1;
  logic [P_WIDTH-1:0] rd_data;

  assign mem_empty = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign s_ready   = !full;

  // A read that landed last cycle is presented straight from the memory output register,
  // which is what gives the two-cycle fall-through; the skid entries take over on a stall.
  assign m_valid = (out_cnt != 2'd0) || land;
  assign m_data  = (out_cnt != 2'd0) ? out0 : (land ? rd_data : '0);

  assign push        = s_valid && s_ready && !rst;
  assign pop         = m_valid && m_ready && !rst;
  assign out_cnt_nxt = out_cnt + {1'b0, land} - {1'b0, pop};
  assign issue       = !mem_empty && (out_cnt_nxt < 2'd2) && !rst;

  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(P_AFULL));
  assign almost_empty = (count <= CW'(P_AEMPTY));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      land    <= 1'b0;
      out_cnt <= 2'd0;
      out0    <= '0;
      out1    <= '0;
      count   <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      land    <= issue;
      out_cnt <= out_cnt_nxt;

      // Occupancy of skid + landed word never exceeds two, so out1 is only ever the tail.
      if (pop) begin
        if (out_cnt == 2'd2) begin
          out0 <= out1;
          if (land) out1 <= rd_data;
        end else if (out_cnt == 2'd1) begin
          if (land) out0 <= rd_data;
        end
      end else if (land) begin
        if (out_cnt == 2'd0) out0 <= rd_data;
        else                 out1 <= rd_data;
      end

      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  fifo_bram #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (P_WIDTH)
  ) u_bram (
    .wr_clk  (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (s_data),
    .rd_clk  (clk),
    .rd_en   (issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: directed vector table, fill/stream/reset sequences and random
// traffic, all scored against a queue-based model of FIFO contents and occupancy.
module tb_fifo_sync_ctrl;

  localparam int DEPTH = 1024;
  localparam int AF    = DEPTH - 16;
  localparam int AE    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;

  fifo_sync_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q[$];
  int         mcount = 0;
  int         npush = 0;
  int         npop = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       ev;
    logic       cd;
    logic [7:0] ed;
    int         ec;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: scores the current outputs, drives one cycle, advances the model.
  task automatic tick(input logic sv, input logic [7:0] sd, input logic mr);
    logic do_push;
    logic do_pop;
    check("count", 32'(count), mcount);
    check("empty", 32'(empty), 32'(mcount == 0));
    check("almost_full", 32'(almost_full), 32'(mcount >= AF));
    check("almost_empty", 32'(almost_empty), 32'(mcount <= AE));
    check("full_is_not_ready", 32'(full), 32'(!s_ready));
    if (mcount == 0) check("m_valid_while_empty", 32'(m_valid), 0);
    if (mcount >= DEPTH + 2) check("s_ready_at_capacity", 32'(s_ready), 0);
    if (mcount < DEPTH) check("s_ready_below_depth", 32'(s_ready), 1);
    if (prev_stall) begin
      check("stall_m_valid", 32'(m_valid), 1);
      check("stall_m_data", 32'(m_data), 32'(prev_data));
    end
    do_push = sv && s_ready;
    do_pop  = m_valid && mr;
    if (do_pop) begin
      if (q.size() == 0) check("pop_with_model_empty", q.size(), 1);
      else               check("pop_data", 32'(m_data), 32'(q.pop_front()));
      npop++;
      mcount--;
    end
    if (do_push) begin
      q.push_back(sd);
      npush++;
      mcount++;
    end
    prev_stall = m_valid && !mr;
    prev_data  = m_data;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk);
  endtask

  task automatic model_clear();
    q.delete();
    mcount     = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 1200 && q.size() > 0; c++) tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check(name, q.size(), 0);
  endtask

  initial begin
    int base_push;
    int base_pop;
    logic seen;

    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3};
    tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 5};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 5};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 4};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2};
    tbl[10] = '{1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 8'h05, 1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA0, 1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0};

    do_reset(3);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_almost_empty", 32'(almost_empty), 1);
    check("rst_almost_full", 32'(almost_full), 0);

    // Fall-through latency, stalled head, in-order pops, push into empty while popping last.
    for (int i = 0; i < 14; i++) begin
      check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
      if (tbl[i].cd) check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].ed));
      check($sformatf("vec%0d_count", i), 32'(count), tbl[i].ec);
      tick(tbl[i].sv, tbl[i].sd, tbl[i].mr);
    end

    // Fill to capacity with the consumer stalled.
    do_reset(1);
    base_push = npush;
    for (int c = 0; c < 1100; c++) tick(1'b1, 8'(c), 1'b0);
    check("fill_words_accepted", npush - base_push, DEPTH + 2);
    check("fill_count", 32'(count), DEPTH + 2);
    check("fill_s_ready", 32'(s_ready), 0);
    check("fill_full", 32'(full), 1);
    check("fill_almost_full", 32'(almost_full), 1);
    drain("fill_drain_complete");

    // Continuous streaming across two pointer wraps.
    base_push = npush;
    base_pop  = npop;
    seen      = 1'b0;
    for (int c = 0; c < 3200 && (npop - base_pop) < 3000; c++) begin
      if (seen) check("stream_no_bubble", 32'(m_valid), 1);
      if (m_valid) seen = 1'b1;
      tick((npush - base_push) < 3000, 8'((npush - base_push) * 7), 1'b1);
    end
    check("stream_words_out", npop - base_pop, 3000);
    check("stream_words_in", npush - base_push, 3000);

    // Ramp with random producer gaps and random consumer stalls.
    base_push = npush;
    base_pop  = npop;
    for (int c = 0; c < 4000 && (npop - base_pop) < 256; c++)
      tick(((npush - base_push) < 256) && ($urandom_range(0, 3) != 0),
           8'(npush - base_push), 1'($urandom_range(0, 1)));
    check("ramp_words_out", npop - base_pop, 256);

    // Free-running random traffic.
    for (int c = 0; c < 2000; c++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    drain("random_drain_complete");

    // Reset mid-operation with a memory read in flight.
    for (int i = 0; i < 38; i++) tick(1'b1, 8'(i + 1), 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check("pre_reset_count", 32'(count), 37);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_empty", 32'(empty), 1);
    tick(1'b1, 8'hA5, 1'b0);
    check("midrst_latency_t1", 32'(m_valid), 0);
    tick(1'b0, 8'h00, 1'b0);
    check("midrst_first_valid", 32'(m_valid), 1);
    check("midrst_first_data", 32'(m_data), 32'h0000_00A5);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check("midrst_final_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
